// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//
// Purpose:
//   Bundles everything that passes between the 5-stage pipeline datapath and
//   the central stall/flush sequencer (pipeline_hazard_ctrl). This covers the
//   hazard-detection inputs from ID/EX/MEM, the per-register enable, flush and
//   bubble controls that go back to the datapath, and the status outputs.
//
// Modports:
//   master : pipeline/datapath side. It drives the hazard inputs and
//            receives the controls.
//   slave  : hazard controller side. It receives the hazard inputs and
//            drives the controls.
//
// Signal summary:
//   id_rs1/id_rs2 [4:0]     source registers of the instruction in ID
//   id_uses_rs1/rs2         ID instruction actually reads that source
//   idex_memread            instruction in EX is a load
//   idex_rd [4:0]           destination register of the instruction in EX
//   branch_taken            EX resolved a taken branch/jump this cycle
//   dmem_req / dmem_ready   MEM-stage access active / completing
//   pc_en, ifid_en, idex_en, exmem_en    register load enables
//   ifid_flush              IF/ID loads a NOP
//   idex_bubble             ID/EX loads zeroed controls
//   memwb_bubble            MEM/WB loads zeroed controls
//   err_timeout             sticky memory-wait timeout flag
//   state_o [1:0]           controller state (INIT=0, RUN=1, MEM_WAIT=2, ERROR=3)
//
// Configuration:
//   HAZARD_PERF_CNT_EN : when defined, the interface gains the CNT_W
//   parameter and three performance-counter signals: stall_cycles,
//   flush_count and loaduse_count.
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if
`ifdef HAZARD_PERF_CNT_EN
    #(parameter int CNT_W = 32)
`endif
    ;

    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       idex_memread;
    logic [4:0] idex_rd;
    logic       branch_taken;
    logic       dmem_req;
    logic       dmem_ready;

    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_en;
    logic       idex_bubble;
    logic       exmem_en;
    logic       memwb_bubble;
    logic       err_timeout;
    logic [1:0] state_o;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic [CNT_W-1:0] loaduse_count;
`endif

    // The datapath presents its hazard information and consumes the
    // controls.
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, idex_memread, idex_rd,
               branch_taken, dmem_req, dmem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
               memwb_bubble, err_timeout, state_o
`ifdef HAZARD_PERF_CNT_EN
               , stall_cycles, flush_count, loaduse_count
`endif
    );

    // The hazard controller sees the same signals from the opposite
    // direction.
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, idex_memread, idex_rd,
               branch_taken, dmem_req, dmem_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
               memwb_bubble, err_timeout, state_o
`ifdef HAZARD_PERF_CNT_EN
               , stall_cycles, flush_count, loaduse_count
`endif
    );

endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose:
//   Central stall/flush sequencer for the 5-stage 64-bit pipeline. It drives
//   the enable, flush and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and
//   MEM/WB registers, and it handles three kinds of hazard:
//     - load-use hazards,
//     - taken-branch flushes,
//     - multi-cycle data-memory waits.
//   After reset it holds the pipeline in a drain, and it traps memory waits
//   that run too long.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   hz   : pipeline_hazard_ctrl_if.slave. It carries the hazard inputs,
//          the pipeline controls, err_timeout, state_o and (optionally) the
//          performance counters.
//
// Parameters:
//   RESET_HOLD  : number of post-reset drain cycles (must be >= 1)
//   MEM_TIMEOUT : maximum number of consecutive MEM_WAIT cycles before
//                 ERROR; 0 disables the timeout
//   CNT_W       : width of the optional performance counters
//
// Configuration:
//   HAZARD_PERF_CNT_EN : when defined, the module adds the saturating
//   counters stall_cycles, flush_count and loaduse_count.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int RESET_HOLD  = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    // A zero-length drain or a zero-width counter would make no sense, so
    // such parameter choices are rejected when the design is elaborated.
    if (RESET_HOLD < 1 || CNT_W < 1) begin : g_badParams
        $error("pipeline_hazard_ctrl: RESET_HOLD and CNT_W must both be >= 1");
    end

    state_t            r_state;
    logic [HOLD_W-1:0] r_holdCnt;
    logic [WAIT_W-1:0] r_waitCnt;
    logic              r_errTimeout;

    logic w_freeze;
    logic w_loadUse;
    logic w_active;
    logic w_doFreeze;
    logic w_doFlush;
    logic w_doLoadBubble;

    // These are the raw hazard terms. A memory access that has not yet
    // completed freezes the whole pipe. A load in EX whose destination
    // register is read by the instruction in ID needs one bubble. Register x0
    // is never a real dependency, so it is excluded.
    assign w_freeze  = hz.dmem_req & ~hz.dmem_ready;
    assign w_loadUse = hz.idex_memread & (hz.idex_rd != 5'd0) &
                       ((hz.id_uses_rs1 & (hz.id_rs1 == hz.idex_rd)) |
                        (hz.id_uses_rs2 & (hz.id_rs2 == hz.idex_rd)));

    // This logic resolves the hazard priority once, so that the control
    // decode and the counters always agree on what happened this cycle.
    // ERROR behaves as a permanent freeze. A branch squashes the ID
    // instruction, so a simultaneous load-use is discarded.
    assign w_active       = (r_state == ST_RUN) || (r_state == ST_MEM_WAIT);
    assign w_doFreeze     = (r_state == ST_ERROR) || (w_active && w_freeze);
    assign w_doFlush      = w_active && !w_freeze && hz.branch_taken;
    assign w_doLoadBubble = w_active && !w_freeze && !hz.branch_taken && w_loadUse;

    // This block is the sequencer state machine. INIT drains the pipe for
    // RESET_HOLD cycles. RUN moves to MEM_WAIT as soon as a memory access
    // stalls. MEM_WAIT returns to RUN in the cycle the memory answers. If the
    // wait outlasts MEM_TIMEOUT, the controller latches into ERROR, which
    // only rst can clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_holdCnt    <= '0;
            r_waitCnt    <= '0;
            r_errTimeout <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_holdCnt <= r_holdCnt + 1'b1;
                    if (r_holdCnt == HOLD_LAST) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_freeze) begin
                        r_state   <= ST_MEM_WAIT;
                        r_waitCnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!w_freeze) begin
                        r_state <= ST_RUN;
                    end else if ((MEM_TIMEOUT != 0) && (r_waitCnt == WAIT_LAST)) begin
                        r_state      <= ST_ERROR;
                        r_errTimeout <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_ERROR;
                end
            endcase
        end
    end

    // This block decodes the pipeline controls from the state and the
    // resolved hazard. Normal flow is the default.
    //   - INIT keeps the PC parked and fills every stage with NOPs.
    //   - A freeze holds every register and lets only a bubble fall into
    //     MEM/WB.
    //   - A branch flush lets the pipe advance but squashes IF/ID and ID/EX.
    //   - A load-use stall holds PC and IF/ID while a bubble goes into ID/EX,
    //     so the load moves on and the dependent instruction retries one
    //     cycle later.
    always_comb begin
        hz.pc_en        = 1'b1;
        hz.ifid_en      = 1'b1;
        hz.ifid_flush   = 1'b0;
        hz.idex_en      = 1'b1;
        hz.idex_bubble  = 1'b0;
        hz.exmem_en     = 1'b1;
        hz.memwb_bubble = 1'b0;
        if (r_state == ST_INIT) begin
            hz.pc_en        = 1'b0;
            hz.ifid_flush   = 1'b1;
            hz.idex_bubble  = 1'b1;
            hz.memwb_bubble = 1'b1;
        end else if (w_doFreeze) begin
            hz.pc_en        = 1'b0;
            hz.ifid_en      = 1'b0;
            hz.idex_en      = 1'b0;
            hz.exmem_en     = 1'b0;
            hz.memwb_bubble = 1'b1;
        end else if (w_doFlush) begin
            hz.ifid_flush   = 1'b1;
            hz.idex_bubble  = 1'b1;
        end else if (w_doLoadBubble) begin
            hz.pc_en        = 1'b0;
            hz.ifid_en      = 1'b0;
            hz.idex_bubble  = 1'b1;
        end
    end

    assign hz.err_timeout = r_errTimeout;
    assign hz.state_o     = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stallCycles;
    logic [CNT_W-1:0] r_flushCount;
    logic [CNT_W-1:0] r_loadUseCount;

    // These are the performance counters. They reuse the resolved hazard
    // decisions above, so a load-use that a branch discards is never counted
    // as a bubble. Each counter sticks at all-ones instead of wrapping, so a
    // long run never reports a misleadingly small number.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCycles  <= '0;
            r_flushCount   <= '0;
            r_loadUseCount <= '0;
        end else begin
            if (w_doFreeze && !(&r_stallCycles)) begin
                r_stallCycles <= r_stallCycles + 1'b1;
            end
            if (w_doFlush && !(&r_flushCount)) begin
                r_flushCount <= r_flushCount + 1'b1;
            end
            if (w_doLoadBubble && !(&r_loadUseCount)) begin
                r_loadUseCount <= r_loadUseCount + 1'b1;
            end
        end
    end

    assign hz.stall_cycles  = r_stallCycles;
    assign hz.flush_count   = r_flushCount;
    assign hz.loaduse_count = r_loadUseCount;
`endif

endmodule
